// File: rtl/gen_counter.sv
// Run-time configurable cycle/event counter with target or unbounded counting,
// abort/restart, saturation flag and run counter. Optional macro: GEN_COUNTER_AUTO_RELOAD_EN.
module gen_counter #(
  parameter int WIDTH    = 16,
  parameter int EVT_SYNC = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             mode_event,
  input  logic             nomax,
  input  logic [WIDTH-1:0] target,
  input  logic             event_in,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             saturated,
  output logic [7:0]       runs
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_d;
  logic [WIDTH-1:0] count_d, target_q, cnt_inc;
  logic             busy_d, done_d, sat_d, load;
  logic [7:0]       runs_d;
  logic             mode_q, nomax_q, evt_inc, inc;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  function automatic logic sat_hit(input logic [WIDTH-1:0] v);
    return &v;
  endfunction

  generate
    if (EVT_SYNC != 0) begin : g_sync
      logic evt_p0, evt_p1, evt_p2;
      // stage: two-flop synchroniser, then edge-history flop
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          evt_p0 <= 1'b0;
          evt_p1 <= 1'b0;
          evt_p2 <= 1'b0;
        end else begin
          evt_p0 <= event_in;
          evt_p1 <= evt_p0;
          evt_p2 <= evt_p1;
        end
      end
      assign evt_inc = evt_p1 & ~evt_p2;
    end else begin : g_direct
      assign evt_inc = event_in;
    end
  endgenerate

  assign inc     = mode_q ? evt_inc : 1'b1;
  assign cnt_inc = count + ONE;

  always_comb begin
    state_d = state;
    count_d = count;
    busy_d  = busy;
    done_d  = 1'b0;
    sat_d   = saturated;
    runs_d  = runs;
    load    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else if (start) begin
      // restart clears the count; a zero target without nomax completes immediately
      load    = 1'b1;
      count_d = '0;
      sat_d   = 1'b0;
      if (target == '0 && !nomax) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        runs_d  = runs + 8'd1;
        state_d = IDLE;
      end else begin
        busy_d  = 1'b1;
        state_d = RUN;
      end
    end else if (state == RUN && inc) begin
      if (nomax_q) begin
        count_d = sat_inc(count);
        if (sat_hit(count_d)) sat_d = 1'b1;
      end else begin
        count_d = cnt_inc;
        if (cnt_inc == target_q) begin
          done_d = 1'b1;
          runs_d = runs + 8'd1;
`ifdef GEN_COUNTER_AUTO_RELOAD_EN
          count_d = '0;
`else
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      saturated <= 1'b0;
      runs      <= 8'd0;
      target_q  <= '0;
      mode_q    <= 1'b0;
      nomax_q   <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      busy      <= busy_d;
      done      <= done_d;
      saturated <= sat_d;
      runs      <= runs_d;
      if (load) begin
        target_q <= target;
        mode_q   <= mode_event;
        nomax_q  <= nomax;
      end
    end
  end

endmodule
